// File: rtl/gf_inv_sub_bytes_iter_pkg.sv
// Shared types, field constants and GF arithmetic helpers for the
// composite-field inverse S-box.
// Field tower: GF(2^2) mod x^2+x+1, GF(2^4) = GF(2^2)[x]/(x^2+x+phi) with phi={10},
// GF(2^8) = GF(2^4)[x]/(x^2+x+lambda) with lambda={1100}. The basis matches the
// forward shared S-box, so the isomorphic map and its inverse are identical there.
// 8x8 matrices are packed {row7,...,row0}; row i is the mask whose parity gives bit i.
package gf_inv_sub_bytes_iter_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [3:0]   nib_t;
  typedef logic [1:0]   crumb_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_state_e;

  localparam logic [63:0] ISO_MAP      = 64'hA0DE_ACAE_C69E_5243;
  localparam logic [63:0] ISO_MAP_INV  = 64'hE244_6276_3E9E_3075;
  // Inverse affine: rotl1 ^ rotl3 ^ rotl6, then add 0x05.
  localparam logic [63:0] INV_AFFINE   = 64'h5229_944A_2592_49A4;
  localparam byte_t       INV_AFFINE_C = 8'h05;
  localparam nib_t        GF4_LAMBDA   = 4'hC;
  localparam crumb_t      GF2_PHI      = 2'b10;

  function automatic byte_t mat_mul(input logic [63:0] m, input byte_t x);
    byte_t r;
    for (int i = 0; i < 8; i++) r[i] = ^(m[8*i +: 8] & x);
    return r;
  endfunction

  function automatic crumb_t gf2_mul(input crumb_t a, input crumb_t b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // In GF(4) the inverse equals the square.
  function automatic crumb_t gf2_inv(input crumb_t a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic nib_t gf4_mul(input nib_t a, input nib_t b);
    crumb_t hh, ll, mm;
    hh = gf2_mul(a[3:2], b[3:2]);
    ll = gf2_mul(a[1:0], b[1:0]);
    mm = gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    return {mm ^ ll, gf2_mul(hh, GF2_PHI) ^ ll};
  endfunction

  function automatic nib_t gf4_sq(input nib_t a);
    return gf4_mul(a, a);
  endfunction

  // Inverse in GF((2^2)^2); 0 maps to 0.
  function automatic nib_t gf4_inv(input nib_t a);
    crumb_t d, di;
    d  = gf2_mul(gf2_mul(a[3:2], a[3:2]), GF2_PHI) ^ gf2_mul(a[3:2], a[1:0])
       ^ gf2_mul(a[1:0], a[1:0]);
    di = gf2_inv(d);
    return {gf2_mul(a[3:2], di), gf2_mul(a[3:2] ^ a[1:0], di)};
  endfunction

endpackage

// File: rtl/gf_inv_sub_bytes_iter_lane.sv
// gf_inv_sbox_lane: one inverse S-box byte lane.
//   clk_i  : clock (used only when PIPE=1)
//   byte_i : input byte
//   byte_o : InvSbox(byte_i), PIPE cycles later
module gf_inv_sbox_lane
  import gf_inv_sub_bytes_iter_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic  clk_i,
  input  byte_t byte_i,
  output byte_t byte_o
);

  byte_t iso_p0;
  nib_t  ah_p0, al_p0, d_p0, dinv_p0;
  nib_t  ah_p1, al_p1, dinv_p1;

  // Stage 0: inverse affine, map into the composite field, invert the norm.
  assign iso_p0  = mat_mul(ISO_MAP, mat_mul(INV_AFFINE, byte_i) ^ INV_AFFINE_C);
  assign ah_p0   = iso_p0[7:4];
  assign al_p0   = iso_p0[3:0];
  assign d_p0    = gf4_mul(gf4_sq(ah_p0), GF4_LAMBDA) ^ gf4_mul(ah_p0, al_p0)
                 ^ gf4_sq(al_p0);
  assign dinv_p0 = gf4_inv(d_p0);

  generate
    if (PIPE != 0) begin : g_pipe
      always_ff @(posedge clk_i) begin
        ah_p1   <= ah_p0;
        al_p1   <= al_p0;
        dinv_p1 <= dinv_p0;
      end
    end else begin : g_comb
      assign ah_p1   = ah_p0;
      assign al_p1   = al_p0;
      assign dinv_p1 = dinv_p0;
    end
  endgenerate

  // Stage 1: finish the inversion and map back to the polynomial basis.
  assign byte_o = mat_mul(ISO_MAP_INV, {gf4_mul(ah_p1, dinv_p1),
                                        gf4_mul(ah_p1 ^ al_p1, dinv_p1)});

endmodule

// File: rtl/gf_inv_sub_bytes_iter.sv
// gf_inv_sub_bytes_iter: iterative InvSubBytes over a 128-bit AES state.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : input handshake (ready only in IDLE)
//   state_in              : byte k = state_in[127-8k -: 8]
//   out_valid / out_ready : output handshake (valid in DONE)
//   state_out             : substituted state, zero outside DONE
//   busy                  : high in RUN or DONE
module gf_inv_sub_bytes_iter
  import gf_inv_sub_bytes_iter_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE  = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t state_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t state_out,
  output logic   busy
);

  localparam int NISSUE = 16 / LANES;
  localparam int CNT_W  = $clog2(NISSUE + 1);

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wb_base;
  logic             issue, wb_en, last_wb, accept;
  byte_t            work_q [16];
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];

  assign accept  = (state_q == S_IDLE) && in_valid;
  assign issue   = (state_q == S_RUN) && (cnt_q < CNT_W'(NISSUE));
  assign last_wb = wb_en && (wb_base == CNT_W'(NISSUE - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue) cnt_d = cnt_q + 1'b1;
        if (last_wb) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-back slot: same cycle as issue, or one cycle later behind the lane register.
  generate
    if (PIPE != 0) begin : g_wb_pipe
      logic             vld_p1_q;
      logic [CNT_W-1:0] wb_cnt_p1_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1_q <= 1'b0;
        else        vld_p1_q <= issue;
      end
      always_ff @(posedge clk) wb_cnt_p1_q <= cnt_q;
      assign wb_en   = vld_p1_q;
      assign wb_base = wb_cnt_p1_q;
    end else begin : g_wb_comb
      assign wb_en   = issue;
      assign wb_base = cnt_q;
    end
  endgenerate

  always_comb begin
    for (int l = 0; l < LANES; l++)
      lane_in[l] = work_q[4'(int'(cnt_q) * LANES + l)];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf_inv_sbox_lane #(.PIPE(PIPE)) u_lane (
      .clk_i  (clk),
      .byte_i (lane_in[l]),
      .byte_o (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 16; k++) work_q[k] <= state_in[127-8*k -: 8];
    end else if (wb_en) begin
      for (int l = 0; l < LANES; l++)
        work_q[4'(int'(wb_base) * LANES + l)] <= lane_out[l];
    end
  end

  always_comb begin
    state_out = '0;
    if (state_q == S_DONE) begin
      for (int k = 0; k < 16; k++) state_out[127-8*k -: 8] = work_q[k];
    end
  end

endmodule

// File: tb/tb_gf_inv_sub_bytes_iter.sv
module tb_gf_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] state_in, state_out;

  logic         sw_in_valid, sw_out_ready;
  logic [127:0] sw_state_in;
  logic [5:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_state_out [6];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf_inv_sub_bytes_iter #(.LANES(4), .PIPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int L = (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 2 : 16);
    localparam int P = g % 2;
    gf_inv_sub_bytes_iter #(.LANES(L), .PIPE(P)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]),
      .state_in(sw_state_in), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
      .state_out(sw_state_out[g]), .busy(sw_busy[g])
    );
  end

  // Reference model in the plain polynomial basis (x^8+x^4+x^3+x+1).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] m_inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept s (engine must be IDLE), then wait for out_valid; lat counts edges after accept.
  task automatic run_state(input logic [127:0] s, output int lat,
                           output logic [127:0] res, output logic rdy_seen);
    state_in = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    do begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    res = state_out;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] V2     = 128'h52097C00_ED160000_00000000_00000000;
  localparam logic [127:0] V2_EXP = 128'h48400152_53FF5252_52525252_52525252;

  initial begin
    int           lat;
    logic         rdy;
    logic [127:0] res, exp_s, held, tmp;
    int           sw_lat [6];
    logic [127:0] sw_dat [6];
    int           sw_exp_lat [6] = '{16, 17, 8, 9, 1, 2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_state_in = '0;
    repeat (3) tick();
    chk("reset_in_ready",  128'(in_ready),  128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy",      128'(busy),      128'(0));
    chk("reset_state_out", state_out,       128'h0);
    rst_n = 1'b1;
    tick();

    // 1: all 0x63 -> all zero, latency 5, never ready while working
    run_state({16{8'h63}}, lat, res, rdy);
    chk("t1_latency", 128'(lat), 128'(5));
    chk("t1_data",    res,       128'h0);
    chk("t1_ready_low", 128'(rdy), 128'(0));
    chk("t1_busy", 128'(busy), 128'(1));
    handshake();
    chk("t1_valid_drop", 128'(out_valid), 128'(0));

    // 2: directed mix
    run_state(V2, lat, res, rdy);
    chk("t2_data",    res,       V2_EXP);
    chk("t2_latency", 128'(lat), 128'(5));
    handshake();

    // 3: all 256 byte values across 16 states
    for (int j = 0; j < 16; j++) begin
      tmp = '0; exp_s = '0;
      for (int k = 0; k < 16; k++) begin
        tmp[127-8*k -: 8]   = 8'(j * 16 + k);
        exp_s[127-8*k -: 8] = m_inv_sbox(8'(j * 16 + k));
      end
      run_state(tmp, lat, res, rdy);
      chk($sformatf("t3_table_%0d", j), res, exp_s);
      exp_s = '0;
      for (int k = 0; k < 16; k++) exp_s[127-8*k -: 8] = m_sbox(res[127-8*k -: 8]);
      chk($sformatf("t3_roundtrip_%0d", j), exp_s, tmp);
      handshake();
    end

    // 4: output backpressure with stray input pulses
    tmp = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_s = '0;
    for (int k = 0; k < 16; k++) exp_s[127-8*k -: 8] = m_inv_sbox(tmp[127-8*k -: 8]);
    run_state(tmp, lat, held, rdy);
    chk("t4_data", held, exp_s);
    for (int c = 0; c < 20; c++) begin
      state_in = {16{8'(c)}};
      in_valid = c[1];
      tick();
      chk($sformatf("t4_hold_valid_%0d", c), 128'(out_valid), 128'(1));
      chk($sformatf("t4_hold_data_%0d", c),  state_out,       exp_s);
    end
    in_valid = 1'b1; out_ready = 1'b1; state_in = V2;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_after_hs_valid", 128'(out_valid), 128'(0));
    chk("t4_no_accept",      128'(in_ready),  128'(1));
    tick();
    chk("t4_single_hs", 128'(out_valid), 128'(0));
    chk("t4_idle_busy", 128'(busy),      128'(0));

    // 5: reset during RUN
    state_in = {16{8'hAB}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_ready", 128'(in_ready),  128'(1));
    chk("t5_rst_busy",  128'(busy),      128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_state(V2, lat, res, rdy);
    chk("t5_after_data",    res,       V2_EXP);
    chk("t5_after_latency", 128'(lat), 128'(5));
    handshake();

    // 6: parameter sweep
    for (int g = 0; g < 6; g++) begin sw_lat[g] = 0; sw_dat[g] = '0; end
    sw_state_in = V2;
    sw_in_valid = 1'b1;
    tick();
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int g = 0; g < 6; g++)
        if (sw_lat[g] == 0 && sw_out_valid[g]) begin
          sw_lat[g] = c;
          sw_dat[g] = sw_state_out[g];
        end
    end
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("t6_latency_%0d", g), 128'(sw_lat[g]), 128'(sw_exp_lat[g]));
      chk($sformatf("t6_data_%0d", g),    sw_dat[g],        V2_EXP);
    end
    sw_out_ready = 1'b1;
    tick();
    sw_out_ready = 1'b0;
    chk("t6_all_drop", 128'(sw_out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
